if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; directly upstream of the decode stage.
- Owns the architectural fetch PC and drives the synchronous-read IROM address.
- Packs {pc4, pc} onto if_to_id_bus and handshakes with decode via valid/allow_in.
- Applies redirects: trap entry/return from CLINT and taken branches/jumps from the controller.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- IF_TO_ID_BUS_WIDTH, 64, equals `IF_TO_ID_BUS_WIDTH: {pc4[31:0], pc[31:0]}.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- br_taken  in  1  controller: branch/jump resolved taken this cycle.
- br_target  in  32  controller: branch/jump target.
- trap_jump  in  1  CLINT: trap entry or mret redirect this cycle.
- trap_addr  in  32  CLINT: mtvec/mepc target.
- hold_flag_if  in  1  controller: freeze fetch.
- id_allow_in  in  1  decode can accept this cycle.
- if_to_id_valid  out  1  IF slot valid and ready to transfer.
- if_to_id_bus  out  64  {pc4, pc}.
- irom_addr  out  32  IROM byte address, sampled by IROM at posedge.

Behaviour:
- State registers:
  - pc_r: PC of the IF slot.
  - if_valid_r: IF slot valid.
  - id_pc_r: PC last handed to decode.
- Reset (rst_n=0 at posedge): pc_r=RESET_PC, id_pc_r=RESET_PC, if_valid_r=0.
- Output values while rst_n is held low:
  - if_to_id_valid=0.
  - irom_addr=RESET_PC.
  - if_to_id_bus={RESET_PC+4, RESET_PC}.
- Cycle after reset release: if_valid_r=1. The first transfer presents pc=RESET_PC.
- redirect = trap_jump | br_taken.
  - target = trap_addr when trap_jump=1, otherwise br_target. Trap has priority when both are asserted.
- if_to_id_valid = if_valid_r & ~redirect & ~hold_flag_if.
- fire = if_to_id_valid & id_allow_in.
- if_to_id_bus = {pc_r+4, pc_r}.
  - 32-bit wrap: pc 32'hFFFF_FFFC gives pc4 32'h0000_0000.
- irom_addr = fire ? pc_r : id_pc_r.
  - The IROM output therefore always matches the PC that decode holds, including while decode stalls.
- Sequential update, in priority order:
  1. redirect: pc_r<=target, if_valid_r<=1. The in-flight IF slot is discarded and no transfer occurs. The redirect takes effect even while hold_flag_if=1.
  2. hold_flag_if: all state holds.
  3. fire: id_pc_r<=pc_r, pc_r<=pc_r+4.
  4. Otherwise (decode stalled): all state holds. Handshake rule: once if_to_id_valid is high, pc_r stays stable until fire or redirect.
- Latency:
  - Redirect at cycle N gives first if_to_id_valid with pc=target at N+1.
  - Fetch throughput is one instruction per cycle when never stalled.
- Reset mid-operation: takes precedence over redirect and hold. State returns to reset values at that edge.
- Target low bits [1:0] with the feature disabled: forced to 2'b00.

Optional Feature:
- Macro IF_MISALIGN_EXC_EN.
- When defined:
  - Adds output fetch_misalign (1 bit) and output fetch_misalign_addr (32 bits).
  - A redirect with target[1:0]!=0 asserts fetch_misalign for exactly 1 cycle, at the edge after the redirect.
  - fetch_misalign_addr captures the raw target.
  - pc_r is not updated and if_valid_r<=0 until the next redirect, which is expected from the trap.
- When undefined: no extra ports; target[1:0] are forced to 0.

Test Plan:
- Reset release with RESET_PC=0, id_allow_in=1 -> valid pcs 0x0,0x4,0x8 on successive cycles; irom_addr equals the presented pc each cycle.
- id_allow_in=0 for 3 cycles at pc=0x10 -> if_to_id_valid stays 1, pc holds at 0x10, irom_addr stays at the previous pc 0x0C; releasing transfers 0x10.
- br_taken=1, br_target=0x100 at pc=0x20 -> no transfer that cycle; next cycle presents pc=0x100, pc4=0x104.
- trap_jump=1 (trap_addr=0x80) and br_taken=1 (0x200) in the same cycle -> next presented pc=0x80.
- hold_flag_if=1 with br_taken to 0x40 -> valid=0 during the hold; after the hold drops, pc=0x40 is presented.
- pc=0xFFFF_FFFC -> pc4=0x0; following pc=0x0. With IF_MISALIGN_EXC_EN: br_target=0x102 -> fetch_misalign 1-cycle pulse, fetch_misalign_addr=0x102, valid=0 until the next redirect.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline.
// Owns the fetch PC, drives the synchronous-read IROM address and hands
// {pc4, pc} to decode through a valid/allow_in handshake. Trap and branch
// redirects override everything except reset.
// Optional feature macro: IF_MISALIGN_EXC_EN. When it is defined, a redirect
// to a target that is not word aligned raises a one-cycle fetch_misalign
// pulse and stops fetching until the next redirect. When it is undefined,
// the target low bits are forced to zero.
module if_stage #(
    parameter logic [31:0] RESET_PC           = 32'h0000_0000,
    parameter int          IF_TO_ID_BUS_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          br_taken,
    input  logic [31:0]                   br_target,
    input  logic                          trap_jump,
    input  logic [31:0]                   trap_addr,
    input  logic                          hold_flag_if,
    input  logic                          id_allow_in,
    output logic                          if_to_id_valid,
    output logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus,
`ifdef IF_MISALIGN_EXC_EN
    output logic                          fetch_misalign,
    output logic [31:0]                   fetch_misalign_addr,
`endif
    output logic [31:0]                   irom_addr
);

    localparam logic [31:0] RESET_PC4 = RESET_PC + 32'd4;

    // Architectural state
    logic [31:0] pc_r;
    logic [31:0] id_pc_r;
    logic        if_valid_r;

    logic [31:0] pc_next;
    logic [31:0] id_pc_next;
    logic        if_valid_next;

    // Redirect decode
    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        fire;
    logic        slot_valid;

    assign redirect   = trap_jump | br_taken;
    // Trap entry/return wins over a branch resolved in the same cycle.
    assign target_raw = trap_jump ? trap_addr : br_target;
    assign pc_plus4   = pc_r + 32'd4;

`ifdef IF_MISALIGN_EXC_EN
    logic        misalign_hit;
    logic        halt_r;
    logic        halt_next;
    logic        fetch_misalign_r;
    logic [31:0] fetch_misalign_addr_r;

    assign target       = target_raw;
    assign misalign_hit = redirect & (target_raw[1:0] != 2'b00);
`else
    assign target       = {target_raw[31:2], 2'b00};
`endif

    // Offer the slot only when no redirect is discarding it and fetch is not frozen.
    assign slot_valid     = if_valid_r & ~redirect & ~hold_flag_if;
    assign fire           = slot_valid & id_allow_in & rst_n;
    assign if_to_id_valid = slot_valid & rst_n;
    assign if_to_id_bus   = rst_n ? {pc_plus4, pc_r} : {RESET_PC4, RESET_PC};
    // On a transfer the IROM fetches the PC moving into decode; otherwise it
    // keeps re-reading decode's PC so its output stays aligned with decode.
    assign irom_addr      = !rst_n ? RESET_PC : (fire ? pc_r : id_pc_r);

    // Next-state selection in priority order: redirect, hold, transfer, stall.
    always_comb begin
        pc_next       = pc_r;
        id_pc_next    = id_pc_r;
        if_valid_next = if_valid_r;
`ifdef IF_MISALIGN_EXC_EN
        halt_next     = halt_r;
`endif
        if (redirect) begin
`ifdef IF_MISALIGN_EXC_EN
            if (misalign_hit) begin
                // Keep the old PC; the trap handler's redirect restarts fetch.
                if_valid_next = 1'b0;
                halt_next     = 1'b1;
            end else begin
                pc_next       = target;
                if_valid_next = 1'b1;
                halt_next     = 1'b0;
            end
`else
            pc_next       = target;
            if_valid_next = 1'b1;
`endif
        end else begin
            // The slot becomes valid the first cycle out of reset and stays so.
`ifdef IF_MISALIGN_EXC_EN
            if_valid_next = ~halt_r;
`else
            if_valid_next = 1'b1;
`endif
            if (!hold_flag_if && fire) begin
                id_pc_next = pc_r;
                pc_next    = pc_plus4;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            id_pc_r    <= RESET_PC;
            if_valid_r <= 1'b0;
        end else begin
            pc_r       <= pc_next;
            id_pc_r    <= id_pc_next;
            if_valid_r <= if_valid_next;
        end
    end

`ifdef IF_MISALIGN_EXC_EN
    // Misaligned-target report: one-cycle pulse plus the raw offending target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halt_r                <= 1'b0;
            fetch_misalign_r      <= 1'b0;
            fetch_misalign_addr_r <= 32'd0;
        end else begin
            halt_r           <= halt_next;
            fetch_misalign_r <= misalign_hit;
            if (misalign_hit) begin
                fetch_misalign_addr_r <= target_raw;
            end
        end
    end

    assign fetch_misalign      = fetch_misalign_r;
    assign fetch_misalign_addr = fetch_misalign_addr_r;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed steps from the test plan followed
// by randomized traffic, all compared against a fetch-stream reference model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_MISALIGN_EXC_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap_jump;
    logic [31:0] trap_addr;
    logic        hold_flag_if;
    logic        id_allow_in;
    logic        if_to_id_valid;
    logic [63:0] if_to_id_bus;
    logic [31:0] irom_addr;
    logic        mis_o;
    logic [31:0] mis_addr_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: next PC to offer, PC decode holds, slot-valid,
    // halted-after-misalign, and the misalign report.
    logic [31:0] m_pc, m_id_pc, m_mis_addr;
    logic        m_valid, m_halt, m_mis;
    logic        e_fire;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RESET_PC), .IF_TO_ID_BUS_WIDTH(64)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .br_taken            (br_taken),
        .br_target           (br_target),
        .trap_jump           (trap_jump),
        .trap_addr           (trap_addr),
        .hold_flag_if        (hold_flag_if),
        .id_allow_in         (id_allow_in),
        .if_to_id_valid      (if_to_id_valid),
        .if_to_id_bus        (if_to_id_bus),
`ifdef IF_MISALIGN_EXC_EN
        .fetch_misalign      (mis_o),
        .fetch_misalign_addr (mis_addr_o),
`endif
        .irom_addr           (irom_addr)
    );
`ifndef IF_MISALIGN_EXC_EN
    assign mis_o      = 1'b0;
    assign mis_addr_o = 32'd0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] raw_target();
        return trap_jump ? trap_addr : br_target;
    endfunction

    // Apply one cycle's inputs, then compare all outputs with the model.
    task automatic drive(input logic r, input logic al, input logic br, input logic [31:0] bt,
                         input logic tj, input logic [31:0] ta, input logic hd);
        logic        e_valid;
        logic [31:0] e_irom;
        logic [63:0] e_bus;
        rst_n = r; id_allow_in = al; br_taken = br; br_target = bt;
        trap_jump = tj; trap_addr = ta; hold_flag_if = hd;
        #2;
        e_valid = r && m_valid && !(br || tj) && !hd;
        e_fire  = e_valid && al;
        e_bus   = r ? {m_pc + 32'd4, m_pc} : {RESET_PC + 32'd4, RESET_PC};
        e_irom  = !r ? RESET_PC : (e_fire ? m_pc : m_id_pc);
        chk("valid", {63'd0, if_to_id_valid}, {63'd0, e_valid});
        chk("bus", if_to_id_bus, e_bus);
        chk("irom_addr", {32'd0, irom_addr}, {32'd0, e_irom});
        if (FEAT) begin
            chk("misalign", {63'd0, mis_o}, {63'd0, m_mis});
            chk("misalign_addr", {32'd0, mis_addr_o}, {32'd0, m_mis_addr});
        end
        $display("[TB] t=%0t rst_n=%0b allow=%0b br=%0b trap=%0b hold=%0b valid=%0b pc=%h irom=%h",
                 $time, r, al, br, tj, hd, if_to_id_valid, if_to_id_bus[31:0], irom_addr);
    endtask

    // Clock edge: advance the model by the fetch rules for the inputs just applied.
    task automatic tick();
        logic [31:0] traw;
        @(posedge clk);
        traw = raw_target();
        if (!rst_n) begin
            m_pc = RESET_PC; m_id_pc = RESET_PC; m_valid = 1'b0;
            m_halt = 1'b0; m_mis = 1'b0; m_mis_addr = 32'd0;
        end else begin
            m_mis = 1'b0;
            if (br_taken || trap_jump) begin
                if (FEAT && traw[1:0] != 2'b00) begin
                    m_valid = 1'b0; m_halt = 1'b1; m_mis = 1'b1; m_mis_addr = traw;
                end else begin
                    m_pc = FEAT ? traw : (traw & 32'hFFFF_FFFC);
                    m_valid = 1'b1; m_halt = 1'b0;
                end
            end else begin
                if (!hold_flag_if && e_fire) begin
                    m_id_pc = m_pc;
                    m_pc    = m_pc + 32'd4;
                end
                m_valid = !m_halt;
            end
        end
        #1;
    endtask

    task automatic run(input logic al);
        drive(1'b1, al, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        tick();
    endtask

    initial begin
        m_pc = RESET_PC; m_id_pc = RESET_PC; m_valid = 1'b0;
        m_halt = 1'b0; m_mis = 1'b0; m_mis_addr = 32'd0; e_fire = 1'b0;
        rst_n = 1'b0; br_taken = 1'b0; br_target = 32'd0; trap_jump = 1'b0;
        trap_addr = 32'd0; hold_flag_if = 1'b0; id_allow_in = 1'b0;
        @(posedge clk); #1;

        // Reset held low.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
            chk("rst_valid", {63'd0, if_to_id_valid}, 64'd0);
            chk("rst_irom", {32'd0, irom_addr}, {32'd0, RESET_PC});
            chk("rst_bus", if_to_id_bus, {RESET_PC + 32'd4, RESET_PC});
            tick();
        end

        // Release: first cycle is idle, then 0,4,8,C stream out.
        run(1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
            chk("stream_pc", {32'd0, if_to_id_bus[31:0]}, 64'(i * 4));
            chk("stream_irom", {32'd0, irom_addr}, 64'(i * 4));
            tick();
        end

        // Decode stall at pc 0x10.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
            chk("stall_valid", {63'd0, if_to_id_valid}, 64'd1);
            chk("stall_pc", {32'd0, if_to_id_bus[31:0]}, 64'h10);
            chk("stall_irom", {32'd0, irom_addr}, 64'h0C);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("release_irom", {32'd0, irom_addr}, 64'h10);
        tick();
        for (int i = 0; i < 3; i++) run(1'b1);

        // Branch taken at pc 0x20.
        drive(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'd0, 1'b0);
        chk("br_pc_before", {32'd0, if_to_id_bus[31:0]}, 64'h20);
        chk("br_no_xfer", {63'd0, if_to_id_valid}, 64'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("br_target", if_to_id_bus, {32'h104, 32'h100});
        tick();

        // Trap and branch together: trap wins.
        drive(1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h80, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("trap_prio", {32'd0, if_to_id_bus[31:0]}, 64'h80);
        tick();

        // Branch during hold, then hold continues.
        drive(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'd0, 1'b1);
        chk("hold_br_valid", {63'd0, if_to_id_valid}, 64'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
            chk("hold_valid", {63'd0, if_to_id_valid}, 64'd0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("hold_release_pc", {32'd0, if_to_id_bus[31:0]}, 64'h40);
        chk("hold_release_valid", {63'd0, if_to_id_valid}, 64'd1);
        tick();

        // 32-bit wrap.
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("wrap_bus", if_to_id_bus, {32'h0, 32'hFFFF_FFFC});
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("wrap_next", {32'd0, if_to_id_bus[31:0]}, 64'h0);
        tick();

        // Misaligned redirect target.
        drive(1'b1, 1'b1, 1'b1, 32'h102, 1'b0, 32'd0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        if (FEAT) begin
            chk("mis_pulse", {63'd0, mis_o}, 64'd1);
            chk("mis_addr", {32'd0, mis_addr_o}, 64'h102);
            chk("mis_valid", {63'd0, if_to_id_valid}, 64'd0);
            tick();
            drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
            chk("mis_pulse_end", {63'd0, mis_o}, 64'd0);
            chk("mis_still_off", {63'd0, if_to_id_valid}, 64'd0);
            tick();
            drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h300, 1'b0);
            tick();
            drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
            chk("mis_recover", {32'd0, if_to_id_bus[31:0]}, 64'h300);
        end else begin
            chk("align_force", {32'd0, if_to_id_bus[31:0]}, 64'h100);
        end
        tick();

        // Reset mid-operation beats a concurrent redirect and hold.
        run(1'b1);
        drive(1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("midrst_valid", {63'd0, if_to_id_valid}, 64'd0);
        chk("midrst_pc", {32'd0, if_to_id_bus[31:0]}, {32'd0, RESET_PC});
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0), $urandom(),
                  ($urandom_range(0, 15) == 0), $urandom(),
                  ($urandom_range(0, 7) == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
